// File: rtl/link_sup_pkg.sv
// Shared encodings and widths for the link bring-up supervisor.
package link_sup_pkg;

    localparam int TIMER_W  = 16;
    localparam int ERRCNT_W = 16;
    localparam int RETRY_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_WAIT_SYNC = 3'd3,
        ST_LINKED    = 3'd4,
        ST_FAIL      = 3'd5
    } link_state_e;

    // The decoder chain is held in reset whenever no training attempt is live.
    function automatic logic holds_decoder_rst(link_state_e s);
        return (s == ST_IDLE) || (s == ST_RESET) || (s == ST_FAIL);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop single-bit synchronizer; output lags the input by two clk edges.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/link_supervisor.sv
// Link bring-up and recovery controller: sequences decoder reset, CDR lock and
// frame sync, then supervises the live link and re-trains with bounded retries.
module link_supervisor
    import link_sup_pkg::*;
#(
    parameter int unsigned RST_HOLD     = 16,
    parameter int unsigned LOCK_TIMEOUT = 4096,
    parameter int unsigned SYNC_TIMEOUT = 8192,
    parameter int unsigned GOOD_FRAMES  = 4,
    parameter int unsigned ERR_THRESH   = 3,
    parameter int unsigned MAX_RETRY    = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                cdr_locked,
    input  logic                sync_lost,
    input  logic                frame_error,
    input  logic                frame_ok,
    input  logic                clear_stats,
    output logic                decoder_rst,
    output logic                link_up,
    output logic                link_fail,
    output logic [2:0]          state,
    output logic [RETRY_W-1:0]  retry_count,
    output logic [ERRCNT_W-1:0] err_count
);

    link_state_e         state_q, state_d;
    logic [TIMER_W-1:0]  timer_q;
    logic [TIMER_W-1:0]  good_q, good_d;
    logic [ERRCNT_W-1:0] consec_q, consec_d;
    logic [ERRCNT_W-1:0] err_d;
    logic [RETRY_W-1:0]  retry_d;
    logic                retry_req;
    logic                lk;
    logic                bad_frame;
    logic                clean_frame;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (cdr_locked),
        .q   (lk)
    );

    // frame_ok is the already-qualified data_valid & data_ready beat; a beat
    // that also carries frame_error is counted as an error, never as clean.
    assign bad_frame   = frame_error;
    assign clean_frame = frame_ok & ~frame_error;

    assign state = state_q;

    always_comb begin
        state_d   = state_q;
        retry_d   = retry_count;
        good_d    = '0;
        consec_d  = '0;
        retry_req = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_RESET;
                    retry_d = '0;
                end
            end
            ST_RESET: begin
                if (timer_q == TIMER_W'(RST_HOLD - 1)) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lk) state_d = ST_WAIT_SYNC;
                else if (timer_q == TIMER_W'(LOCK_TIMEOUT - 1)) retry_req = 1'b1;
            end
            ST_WAIT_SYNC: begin
                if (bad_frame || sync_lost) good_d = '0;
                else if (clean_frame)       good_d = good_q + TIMER_W'(1);
                else                        good_d = good_q;

                if (!lk || (timer_q == TIMER_W'(SYNC_TIMEOUT - 1))) begin
                    retry_req = 1'b1;
                end else if (clean_frame && !sync_lost &&
                             (good_q == TIMER_W'(GOOD_FRAMES - 1))) begin
                    state_d = ST_LINKED;
                    retry_d = '0;
                end
            end
            ST_LINKED: begin
                if (bad_frame)     consec_d = consec_q + ERRCNT_W'(1);
                else if (frame_ok) consec_d = '0;
                else               consec_d = consec_q;

                if ((consec_d >= ERRCNT_W'(ERR_THRESH)) || sync_lost || !lk) begin
                    retry_req = 1'b1;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Several simultaneous retry causes collapse into this single action.
        if (retry_req) begin
            if (retry_count == RETRY_W'(MAX_RETRY)) begin
                state_d = ST_FAIL;
            end else begin
                state_d = ST_RESET;
                retry_d = retry_count + RETRY_W'(1);
            end
        end

        if (!enable) begin
            state_d = ST_IDLE;
            retry_d = retry_count;
        end
    end

    always_comb begin
        err_d = err_count;
        if (clear_stats) begin
            err_d = '0;
        end else if (frame_error && (state_q == ST_WAIT_SYNC || state_q == ST_LINKED) &&
                     (err_count != {ERRCNT_W{1'b1}})) begin
            err_d = err_count + ERRCNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            good_q      <= '0;
            consec_q    <= '0;
            retry_count <= '0;
            err_count   <= '0;
            decoder_rst <= 1'b1;
            link_up     <= 1'b0;
            link_fail   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= (state_d != state_q) ? '0 : timer_q + TIMER_W'(1);
            good_q      <= (state_d == ST_WAIT_SYNC) ? good_d : '0;
            consec_q    <= (state_d == ST_LINKED) ? consec_d : '0;
            retry_count <= retry_d;
            err_count   <= err_d;
            decoder_rst <= holds_decoder_rst(state_d);
            link_up     <= (state_d == ST_LINKED);
            link_fail   <= (state_d == ST_FAIL);
        end
    end

endmodule

// File: tb/tb_link_supervisor.sv
// Bench for link_supervisor: cycle model plus directed bring-up, retry, stats scenarios.
module tb_link_supervisor;

    localparam int W = 25;
    localparam int S_IDLE = 0, S_RESET = 1, S_LOCK = 2, S_SYNC = 3, S_LINK = 4, S_FAIL = 5;
    localparam int RST_HOLD = 16, LOCK_TO = 4096, SYNC_TO = 8192, GOOD = 4, MAXR = 7;
    localparam int ETHR_A = 3, ETHR_B = 1024;

    typedef struct {
        int st;
        int tmr;
        int good;
        int consec;
        int retry;
        int errc;
        bit lk1;
        bit lk2;
    } mdl_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1, en_a = 1'b0, cdr_a = 1'b0, sl_a = 1'b0, fe_a = 1'b0, fo_a = 1'b0, cs_a = 1'b0;
    logic rst_b = 1'b1, en_b = 1'b0, cdr_b = 1'b0, sl_b = 1'b0, fe_b = 1'b0, fo_b = 1'b0, cs_b = 1'b0;
    logic drst_a, lup_a, lfail_a, drst_b, lup_b, lfail_b;
    logic [2:0] st_a, rc_a, st_b, rc_b;
    logic [15:0] ec_a, ec_b;

    logic [W-1:0] exp_q_a[$];
    logic [W-1:0] exp_q_b[$];
    mdl_t m_a, m_b;
    int n_checks = 0;
    int n_fail = 0;

    link_supervisor u_dut_a (
        .clk(clk), .rst(rst_a), .enable(en_a), .cdr_locked(cdr_a), .sync_lost(sl_a),
        .frame_error(fe_a), .frame_ok(fo_a), .clear_stats(cs_a), .decoder_rst(drst_a),
        .link_up(lup_a), .link_fail(lfail_a), .state(st_a), .retry_count(rc_a), .err_count(ec_a)
    );

    link_supervisor #(.ERR_THRESH(ETHR_B)) u_dut_b (
        .clk(clk), .rst(rst_b), .enable(en_b), .cdr_locked(cdr_b), .sync_lost(sl_b),
        .frame_error(fe_b), .frame_ok(fo_b), .clear_stats(cs_b), .decoder_rst(drst_b),
        .link_up(lup_b), .link_fail(lfail_b), .state(st_b), .retry_count(rc_b), .err_count(ec_b)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    function automatic mdl_t step(mdl_t c, bit r, bit en, bit cdr, bit sl, bit fe, bit fo,
                                  bit cs, int ethr);
        mdl_t n;
        bit lk, retry, clean;
        int nst, g, e;
        n = c;
        if (r) begin
            n = '{default: 0};
            return n;
        end
        lk    = c.lk2;
        n.lk2 = c.lk1;
        n.lk1 = cdr;
        clean = fo && !fe;
        retry = 1'b0;
        nst   = c.st;
        if (cs) n.errc = 0;
        else if (fe && (c.st == S_SYNC || c.st == S_LINK) && c.errc < 65535) n.errc = c.errc + 1;
        n.good   = 0;
        n.consec = 0;
        if (c.st == S_IDLE && en) begin
            nst     = S_RESET;
            n.retry = 0;
        end else if (c.st == S_RESET && c.tmr + 1 == RST_HOLD) begin
            nst = S_LOCK;
        end else if (c.st == S_LOCK) begin
            if (lk) nst = S_SYNC;
            else if (c.tmr + 1 == LOCK_TO) retry = 1'b1;
        end else if (c.st == S_SYNC) begin
            g = (fe || sl) ? 0 : (clean ? c.good + 1 : c.good);
            n.good = g;
            if (!lk || c.tmr + 1 == SYNC_TO) retry = 1'b1;
            else if (clean && !sl && c.good + 1 == GOOD) begin
                nst     = S_LINK;
                n.retry = 0;
            end
        end else if (c.st == S_LINK) begin
            e = fe ? c.consec + 1 : (fo ? 0 : c.consec);
            n.consec = e;
            if (e >= ethr || sl || !lk) retry = 1'b1;
        end
        if (retry) begin
            if (c.retry == MAXR) nst = S_FAIL;
            else begin
                nst     = S_RESET;
                n.retry = c.retry + 1;
            end
        end
        if (!en) begin
            nst     = S_IDLE;
            n.retry = c.retry;
        end
        if (nst != S_SYNC) n.good = 0;
        if (nst != S_LINK) n.consec = 0;
        n.tmr = (nst != c.st) ? 0 : (c.tmr + 1) % 65536;
        n.st  = nst;
        return n;
    endfunction

    function automatic logic [W-1:0] pack(mdl_t x);
        logic drst;
        drst = (x.st == S_IDLE) || (x.st == S_RESET) || (x.st == S_FAIL);
        return {3'(x.st), drst, x.st == S_LINK, x.st == S_FAIL, 3'(x.retry), 16'(x.errc)};
    endfunction

    initial begin
        m_a = '{default: 0};
        m_b = '{default: 0};
        forever begin
            @(posedge clk);
            m_a = step(m_a, rst_a, en_a, cdr_a, sl_a, fe_a, fo_a, cs_a, ETHR_A);
            m_b = step(m_b, rst_b, en_b, cdr_b, sl_b, fe_b, fo_b, cs_b, ETHR_B);
            exp_q_a.push_back(pack(m_a));
            exp_q_b.push_back(pack(m_b));
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q_a.size() > 0)
                chk("model_a", 32'({st_a, drst_a, lup_a, lfail_a, rc_a, ec_a}), 32'(exp_q_a.pop_front()));
            if (exp_q_b.size() > 0)
                chk("model_b", 32'({st_b, drst_b, lup_b, lfail_b, rc_b, ec_b}), 32'(exp_q_b.pop_front()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_a(input logic fe, input logic fo, input logic cs, input logic sl);
        tick();
        fe_a = fe; fo_a = fo; cs_a = cs; sl_a = sl;
        tick();
        fe_a = 1'b0; fo_a = 1'b0; cs_a = 1'b0; sl_a = 1'b0;
    endtask

    task automatic wait_a(input int s, input int budget, input string name);
        int n = 0;
        while (int'(st_a) != s && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(st_a), 32'(s));
    endtask

    task automatic frames_a(input int gap);
        for (int k = 0; k < 4; k++) begin
            repeat (gap) tick();
            apply_a(1'b0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic attempt_a(output int n);
        n = 0;
        while (st_a == 3'd1 && n < 100) begin tick(); n++; end
        while (st_a == 3'd2 && n < 5000) begin tick(); n++; end
    endtask

    // ---------------- instance A scenarios ----------------
    task automatic run_a();
        int n;
        tick();
        chk("rst_state", 32'(st_a), 0);
        chk("rst_drst", 32'(drst_a), 1);
        chk("rst_counts", 32'({lup_a, lfail_a, rc_a, ec_a}), 0);
        rst_a = 1'b0;

        // clean bring-up
        en_a = 1'b1;
        tick();
        chk("bringup_reset", 32'(st_a), 1);
        n = 0;
        while (drst_a && n < 40) begin tick(); n++; end
        chk("drst_hold_cycles", 32'(n), 16);
        chk("bringup_wait_lock", 32'(st_a), 2);
        repeat (83) tick();
        cdr_a = 1'b1;
        wait_a(3, 10, "bringup_wait_sync");
        for (int k = 0; k < 3; k++) begin
            repeat (9) tick();
            apply_a(1'b0, 1'b1, 1'b0, 1'b0);
        end
        chk("three_frames_not_up", 32'(lup_a), 0);
        repeat (9) tick();
        apply_a(1'b0, 1'b1, 1'b0, 1'b0);
        chk("bringup_link_up", 32'({st_a, lup_a, rc_a}), 32'({3'd4, 1'b1, 3'd0}));

        // error burst: interrupted run, then three consecutive errors
        apply_a(1'b1, 1'b0, 1'b0, 1'b0);
        apply_a(1'b0, 1'b1, 1'b0, 1'b0);
        apply_a(1'b1, 1'b0, 1'b0, 1'b0);
        apply_a(1'b1, 1'b0, 1'b0, 1'b0);
        chk("burst_still_linked", 32'(st_a), 4);
        chk("burst_err_count", 32'(ec_a), 3);
        apply_a(1'b0, 1'b1, 1'b1, 1'b0);
        apply_a(1'b1, 1'b0, 1'b0, 1'b0);
        apply_a(1'b1, 1'b0, 1'b0, 1'b0);
        chk("two_errs_linked", 32'(st_a), 4);
        apply_a(1'b1, 1'b0, 1'b0, 1'b0);
        chk("third_err_retry", 32'({st_a, rc_a, ec_a}), 32'({3'd1, 3'd1, 16'd3}));

        // re-link, then sync loss
        wait_a(3, 40, "relink1_sync");
        frames_a(1);
        chk("relink1_up", 32'({st_a, rc_a}), 32'({3'd4, 3'd0}));
        apply_a(1'b0, 1'b0, 1'b0, 1'b1);
        chk("sync_lost_retry", 32'({st_a, rc_a}), 32'({3'd1, 3'd1}));
        wait_a(3, 40, "relink2_sync");
        frames_a(1);
        chk("relink2_up", 32'(st_a), 4);

        // lock loss shows up after the synchronizer delay
        tick();
        cdr_a = 1'b0;
        tick();
        tick();
        chk("lock_drop_2cyc", 32'(st_a), 4);
        tick();
        chk("lock_drop_3cyc", 32'({st_a, rc_a}), 32'({3'd1, 3'd1}));

        // enable drop during WAIT_SYNC
        wait_a(2, 30, "pri_wait_lock");
        cdr_a = 1'b1;
        wait_a(3, 10, "pri_wait_sync");
        tick();
        en_a = 1'b0;
        tick();
        chk("enable_drop_idle", 32'({st_a, drst_a}), 32'({3'd0, 1'b1}));

        // lock timeout chain into FAIL
        cdr_a = 1'b0;
        repeat (4) tick();
        en_a = 1'b1;
        tick();
        attempt_a(n);
        chk("lock_timeout_cycles", 32'(n), 4112);
        chk("lock_timeout_retry1", 32'({st_a, rc_a}), 32'({3'd1, 3'd1}));
        for (int k = 2; k <= 7; k++) begin
            attempt_a(n);
            chk("lock_timeout_retry", 32'({st_a, rc_a}), 32'({3'd1, 3'(k)}));
        end
        attempt_a(n);
        chk("fail_entered", 32'({st_a, lfail_a, drst_a, lup_a}), 32'({3'd5, 1'b1, 1'b1, 1'b0}));
        repeat (5) tick();
        chk("fail_held", 32'(st_a), 5);
        en_a = 1'b0;
        tick();
        chk("fail_release", 32'({st_a, lfail_a}), 32'({3'd0, 1'b0}));

        // stats clearing and mid-operation reset
        en_a = 1'b1;
        cdr_a = 1'b1;
        wait_a(3, 40, "final_sync");
        frames_a(1);
        chk("final_up_retry_clr", 32'({st_a, rc_a}), 32'({3'd4, 3'd0}));
        apply_a(1'b1, 1'b0, 1'b0, 1'b0);
        chk("err_inc", 32'(ec_a), 4);
        apply_a(1'b0, 1'b1, 1'b0, 1'b0);
        apply_a(1'b1, 1'b0, 1'b1, 1'b0);
        chk("clear_beats_err", 32'(ec_a), 0);
        apply_a(1'b0, 1'b1, 1'b0, 1'b0);
        apply_a(1'b1, 1'b0, 1'b0, 1'b0);
        chk("err_after_clear", 32'(ec_a), 1);
        rst_a = 1'b1;
        tick();
        chk("midrun_rst", 32'({st_a, drst_a, lup_a, lfail_a, rc_a, ec_a}),
            32'({3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 16'd0}));
        rst_a = 1'b0;
        en_a = 1'b0;
        tick();
    endtask

    // ---------------- instance B: err_count saturation ----------------
    task automatic run_b();
        int n = 0;
        tick();
        rst_b = 1'b0;
        en_b = 1'b1;
        cdr_b = 1'b1;
        while (st_b != 3'd3 && n < 60) begin tick(); n++; end
        chk("b_wait_sync", 32'(st_b), 3);
        for (int k = 0; k < 4; k++) begin
            tick(); fo_b = 1'b1;
            tick(); fo_b = 1'b0;
        end
        chk("b_linked", 32'(st_b), 4);
        for (int k = 0; k < 65541; k++) begin
            tick();
            fe_b = 1'b1; fo_b = 1'b0;
            if (k % 1000 == 999) begin
                tick();
                fe_b = 1'b0; fo_b = 1'b1;
            end
        end
        tick();
        fe_b = 1'b0; fo_b = 1'b0;
        chk("b_saturated", 32'({st_b, ec_b}), 32'({3'd4, 16'hFFFF}));
        tick();
        fe_b = 1'b1; cs_b = 1'b1;
        tick();
        fe_b = 1'b0; cs_b = 1'b0;
        chk("b_clear_coincident", 32'(ec_b), 0);
    endtask

    // ---------------- main + final report ----------------
    initial begin
        fork
            run_a();
            run_b();
        join
        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #950000;
        n_fail++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/link_supervisor.md
Name: link_supervisor

Overview:
- Link-bring-up and recovery controller for the single-wire Manchester receive chain: soft CDR, then frame sync, then data output.
- Sequences the decoder out of reset and waits for CDR lock, then for stable framing.
- Monitors lock, sync and CRC errors while linked; re-trains by pulsing the decoder reset, with bounded retries.
- Sits in the clk_link (80 MHz) domain next to spi_coax_decoder; its decoder_rst drives the decoder's reset.

Parameters:
- RST_HOLD, 16, cycles decoder_rst is held high per training attempt (>=1).
- LOCK_TIMEOUT, 4096, cycles allowed in WAIT_LOCK before retry.
- SYNC_TIMEOUT, 8192, cycles allowed in WAIT_SYNC before retry.
- GOOD_FRAMES, 4, consecutive clean frames required to declare link up.
- ERR_THRESH, 3, consecutive frame errors in LINKED that force a retry.
- MAX_RETRY, 7, failed attempts before FAIL (fits retry_count width 3).

Ports:
- clk  in  1  link clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  level; 1 = bring up and keep the link.
- cdr_locked  in  1  CDR lock flag from the 240 MHz domain; double-flopped internally.
- sync_lost  in  1  frame sync lost, level, clk domain.
- frame_error  in  1  one-cycle CRC/frame error pulse.
- frame_ok  in  1  one-cycle pulse = data_valid & data_ready.
- clear_stats  in  1  one-cycle pulse, zeroes err_count.
- decoder_rst  out  1  active-high reset to the decoder chain.
- link_up  out  1  high only in LINKED.
- link_fail  out  1  high only in FAIL.
- state  out  3  IDLE=0, RESET=1, WAIT_LOCK=2, WAIT_SYNC=3, LINKED=4, FAIL=5.
- retry_count  out  3  failed attempts in the current bring-up.
- err_count  out  16  saturating frame_error count.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, decoder_rst=1, link_up=0, link_fail=0, retry_count=0, err_count=0; timer, good and consecutive-error counters = 0.
- Output timing: all outputs registered; they reflect the new state the cycle after the triggering input. cdr_locked adds 2 cycles of synchronizer latency (lk = synced value).
- Timer: 16-bit, cleared on every state entry, increments each cycle.
- IDLE:
  - decoder_rst=1.
  - enable=1 -> RESET; retry_count=0.
- RESET:
  - decoder_rst=1.
  - When timer==RST_HOLD-1 -> WAIT_LOCK. decoder_rst is high exactly RST_HOLD cycles.
- WAIT_LOCK:
  - decoder_rst=0.
  - lk=1 -> WAIT_SYNC.
  - Otherwise timer==LOCK_TIMEOUT-1 -> RETRY action.
- WAIT_SYNC:
  - Good counter: frame_ok with no frame_error increments it; frame_error or sync_lost clears it.
  - good==GOOD_FRAMES-1 while frame_ok -> LINKED; retry_count cleared on entry.
  - lk=0 or timer==SYNC_TIMEOUT-1 -> RETRY.
- LINKED:
  - link_up=1.
  - frame_error increments the consecutive-error counter; frame_ok alone clears it.
  - Consecutive count reaching ERR_THRESH, sync_lost=1, or lk=0 -> RETRY. The timer is unused.
- RETRY action (not a state):
  - retry_count==MAX_RETRY -> FAIL.
  - Otherwise retry_count+1 -> RESET.
- FAIL:
  - decoder_rst=1, link_fail=1.
  - Held until enable=0.
- enable=0 in any state -> IDLE next cycle. Takes priority over all other transitions.
- Simultaneous events:
  - frame_ok and frame_error in the same cycle: treated as an error.
  - Multiple RETRY causes in one cycle: a single RETRY.
- err_count: +1 per frame_error in WAIT_SYNC or LINKED; saturates at 16'hFFFF. clear_stats wins over a coincident error (result 0). Not cleared by RETRY or IDLE, only by rst or clear_stats.
- rst mid-operation: all state returns to reset values on the next edge; decoder_rst asserts immediately on that edge.

Decomposition:
- Package link_sup_pkg:
  - state encoding enum (3 bits);
  - TIMER_W=16, ERRCNT_W=16, RETRY_W=3.
- One sub-module: sync_2ff, a 2-flop bit synchronizer for cdr_locked. The FSM, timers and counters stay in link_supervisor.

Test Plan:
- Clean bring-up: rst, then enable=1; cdr_locked rises 100 cycles later; then 4 frame_ok pulses 10 cycles apart.
  -> decoder_rst high exactly 16 cycles; state goes 0,1,2,3,4; link_up=1 the cycle after the 4th frame_ok; retry_count=0.
- Lock timeout: enable=1, cdr_locked held 0.
  -> state returns to RESET after 16+4096 cycles with retry_count=1. After 7 failed attempts the next timeout enters FAIL (link_fail=1, decoder_rst=1). enable=0 -> IDLE.
- Error burst in LINKED: errors, frame_ok, errors.
  -> frame_error, frame_ok, frame_error, frame_error: no retry, stays LINKED.
  -> 3rd consecutive error: RESET next cycle, retry_count=1, err_count=3.
- Sync/lock loss: sync_lost pulsed in LINKED -> RESET next cycle. cdr_locked dropped in LINKED -> RESET 3 cycles later.
- Stats:
  - 0x10005 frame_error pulses in LINKED (ERR_THRESH raised for this test) -> err_count=16'hFFFF.
  - clear_stats coincident with frame_error -> err_count=0.
- Priority and reset: enable=0 during WAIT_SYNC -> IDLE next cycle, decoder_rst=1; rst asserted in LINKED -> all outputs at reset values next cycle.
